// File: rtl/riscv_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Shared encodings for the multicycle RV32I control unit.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } ctrlState_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b101;

  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_J = 3'b011;
  localparam logic [2:0] c_IMM_U = 3'b100;

  // Unsupported opcodes fall back to the I-format select.
  function automatic logic [2:0] immSrcFor(input logic [6:0] op);
    case (op)
      c_OP_STORE:  immSrcFor = c_IMM_S;
      c_OP_BRANCH: immSrcFor = c_IMM_B;
      c_OP_JAL:    immSrcFor = c_IMM_J;
      c_OP_LUI:    immSrcFor = c_IMM_U;
      default:     immSrcFor = c_IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational ALUOp/funct decode to the ALU operation select.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       opb5,
  input  logic       funct7b5,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = c_ALU_ADD;
    case (aluOp)
      c_ALUOP_SUB: aluControl = c_ALU_SUB;
      c_ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type honours funct7b5; addi reuses the same funct3.
          3'b000:  aluControl = (opb5 & funct7b5) ? c_ALU_SUB : c_ALU_ADD;
          3'b010:  aluControl = c_ALU_SLT;
          3'b110:  aluControl = c_ALU_OR;
          3'b111:  aluControl = c_ALU_AND;
          default: aluControl = c_ALU_ADD;
        endcase
      end
      default: aluControl = c_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore FSM control unit for the multicycle RV32I datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite
);

  ctrlState_t r_state;
  ctrlState_t w_nextState;

  logic       w_pcUpdate;
  logic       w_branch;
  logic       w_taken;
  logic [1:0] w_aluOp;
  logic       w_irWrite;
  logic       w_regWrite;
  logic       w_memWrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = FETCH;
    w_pcUpdate  = 1'b0;
    w_branch    = 1'b0;
    w_aluOp     = c_ALUOP_ADD;
    w_irWrite   = 1'b0;
    w_regWrite  = 1'b0;
    w_memWrite  = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    case (r_state)
      FETCH: begin
        w_irWrite   = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pcUpdate  = 1'b1;
        w_nextState = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here while the register file reads.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          c_OP_LOAD, c_OP_STORE: w_nextState = MEMADR;
          c_OP_RTYPE:            w_nextState = EXECUTER;
          c_OP_ITYPE:            w_nextState = EXECUTEI;
          c_OP_BRANCH:           w_nextState = BEQ;
          c_OP_JAL:              w_nextState = JAL;
          c_OP_LUI:              w_nextState = LUI;
          default:               w_nextState = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA     = 2'b10;
        ALUSrcB     = 2'b01;
        w_nextState = (op == c_OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc      = 1'b1;
        w_nextState = MEMWB;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        w_regWrite  = 1'b1;
        w_nextState = FETCH;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_memWrite  = 1'b1;
        w_nextState = FETCH;
      end
      EXECUTER: begin
        ALUSrcA     = 2'b10;
        w_aluOp     = c_ALUOP_FUNCT;
        w_nextState = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA     = 2'b10;
        ALUSrcB     = 2'b01;
        w_aluOp     = c_ALUOP_FUNCT;
        w_nextState = ALUWB;
      end
      ALUWB: begin
        w_regWrite  = 1'b1;
        w_nextState = FETCH;
      end
      BEQ: begin
        ALUSrcA     = 2'b10;
        w_aluOp     = c_ALUOP_SUB;
        w_branch    = 1'b1;
        w_nextState = FETCH;
      end
      JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pcUpdate  = 1'b1;
        w_nextState = ALUWB;
      end
      LUI: begin
        ResultSrc   = 2'b11;
        w_regWrite  = 1'b1;
        w_nextState = FETCH;
      end
      default: w_nextState = FETCH;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      default: w_taken = 1'b0;
    endcase
  end

  // Enables are gated by rst_n so none can pulse while reset is held.
  assign PCWrite  = rst_n & (w_pcUpdate | (w_branch & w_taken));
  assign IRWrite  = rst_n & w_irWrite;
  assign RegWrite = rst_n & w_regWrite;
  assign MemWrite = rst_n & w_memWrite;

  assign ImmSrc = immSrcFor(op);

  alu_decoder u_aluDecoder (
    .aluOp      (w_aluOp),
    .funct3     (funct3),
    .opb5       (op[5]),
    .funct7b5   (funct7b5),
    .aluControl (ALUControl)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Random instruction stream checked against a per-phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       regw;
  } outs_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_LUI = 6, K_BAD = 7;
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
                 P_ER = 6, P_EI = 7, P_AWB = 8, P_BR = 9, P_J = 10, P_LUI = 11;

  int    vectors = 0;
  int    misses  = 0;
  int    expMode = 0;
  outs_t expOut  = '0;
  int    curKind = 0;
  int    curPhase = 0;
  logic  litActive = 1'b0;
  outs_t litMask = '0;
  outs_t litVal  = '0;
  outs_t dutOut;

  assign dutOut = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, RegWrite};

  function automatic logic [6:0] opFor(input int kind);
    case (kind)
      K_LW:    opFor = 7'b0000011;
      K_SW:    opFor = 7'b0100011;
      K_R:     opFor = 7'b0110011;
      K_I:     opFor = 7'b0010011;
      K_BR:    opFor = 7'b1100011;
      K_JAL:   opFor = 7'b1101111;
      K_LUI:   opFor = 7'b0110111;
      default: opFor = 7'b1111111;
    endcase
  endfunction

  function automatic int instrLen(input int kind);
    case (kind)
      K_LW:          instrLen = 5;
      K_BR, K_LUI:   instrLen = 3;
      K_BAD:         instrLen = 2;
      default:       instrLen = 4;
    endcase
  endfunction

  function automatic int phaseOf(input int kind, input int idx);
    phaseOf = (idx == 0) ? P_F : P_D;
    if (idx >= 2) begin
      case (kind)
        K_LW:    phaseOf = (idx == 2) ? P_MA : (idx == 3) ? P_MR : P_MWB;
        K_SW:    phaseOf = (idx == 2) ? P_MA : P_MW;
        K_R:     phaseOf = (idx == 2) ? P_ER : P_AWB;
        K_I:     phaseOf = (idx == 2) ? P_EI : P_AWB;
        K_BR:    phaseOf = P_BR;
        K_JAL:   phaseOf = (idx == 2) ? P_J : P_AWB;
        default: phaseOf = P_LUI;
      endcase
    end
  endfunction

  function automatic logic [2:0] immFor(input int kind);
    case (kind)
      K_SW:    immFor = 3'b001;
      K_BR:    immFor = 3'b010;
      K_JAL:   immFor = 3'b011;
      K_LUI:   immFor = 3'b100;
      default: immFor = 3'b000;
    endcase
  endfunction

  // Arithmetic operation an R/I instruction asks for.
  function automatic logic [2:0] aluFor(input int kind, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  aluFor = (kind == K_R && f7) ? 3'b001 : 3'b000;
      3'b010:  aluFor = 3'b101;
      3'b110:  aluFor = 3'b011;
      3'b111:  aluFor = 3'b010;
      default: aluFor = 3'b000;
    endcase
  endfunction

  function automatic outs_t modelOut(input int ph, input int kind, input logic [2:0] f3,
                                     input logic f7, input logic z);
    outs_t o;
    o = '0;
    o.imm = immFor(kind);
    case (ph)
      P_F:   begin o.irw = 1; o.srcB = 2'b10; o.res = 2'b10; o.pcw = 1; end
      P_D:   begin o.srcA = 2'b01; o.srcB = 2'b01; end
      P_MA:  begin o.srcA = 2'b10; o.srcB = 2'b01; end
      P_MR:  o.adr = 1;
      P_MWB: begin o.res = 2'b01; o.regw = 1; end
      P_MW:  begin o.adr = 1; o.memw = 1; end
      P_ER:  begin o.srcA = 2'b10; o.alu = aluFor(kind, f3, f7); end
      P_EI:  begin o.srcA = 2'b10; o.srcB = 2'b01; o.alu = aluFor(kind, f3, f7); end
      P_AWB: o.regw = 1;
      P_BR:  begin o.srcA = 2'b10; o.alu = 3'b001; o.pcw = (f3 == 3'b000) ? z : ~z; end
      P_J:   begin o.srcA = 2'b01; o.srcB = 2'b10; o.pcw = 1; end
      default: begin o.res = 2'b11; o.regw = 1; end
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (expMode == 1) begin
      vectors++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
        misses++;
        $display("FAIL reset_enables t=%0t got PCW/IRW/RW/MW=%b need 0000", $time,
                 {PCWrite, IRWrite, RegWrite, MemWrite});
      end
    end else if (expMode == 2) begin
      vectors++;
      if (dutOut !== expOut) begin
        misses++;
        $display("FAIL outputs t=%0t kind=%0d phase=%0d got=%b need=%b", $time,
                 curKind, curPhase, dutOut, expOut);
      end
    end
    if (litActive) begin
      vectors++;
      if ((dutOut & litMask) !== litVal) begin
        misses++;
        $display("FAIL literal t=%0t kind=%0d got=%b need=%b (mask %b)", $time,
                 curKind, dutOut & litMask, litVal, litMask);
      end
    end
  end

  task automatic doCycle(input logic r, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z, input int mode, input outs_t e);
    @(posedge clk);
    #1;
    rst_n = r; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    expMode = mode; expOut = e; litActive = 1'b0;
  endtask

  task automatic runInstr(input int kind, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input int forceZero, input int abortAt,
                          input int litIdx, input outs_t lm, input outs_t lv);
    logic z;
    int   nres;
    curKind = kind;
    for (int idx = 0; idx < instrLen(kind); idx++) begin
      if (idx == abortAt) begin
        nres = 1 + int'($urandom_range(0, 1));
        for (int r = 0; r < nres; r++) doCycle(1'b0, o, f3, f7, 1'b0, 1, '0);
        return;
      end
      z = (forceZero >= 0) ? forceZero[0] : 1'($urandom);
      curPhase = phaseOf(kind, idx);
      doCycle(1'b1, o, f3, f7, z, 2, modelOut(curPhase, kind, f3, f7, z));
      if (idx == litIdx) begin
        litMask = lm; litVal = lv; litActive = 1'b1;
      end
    end
  endtask

  outs_t m, v;
  logic [6:0] badOps [5] = '{7'b1111111, 7'b0000000, 7'b0010111, 7'b1100111, 7'b1110011};

  initial begin
    rst_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
    for (int i = 0; i < 3; i++) doCycle(1'b0, 7'b0, 3'b0, 1'b0, 1'b0, 1, '0);

    // First cycle after release: FETCH with IRWrite, PCWrite, ALUSrcB=10.
    m = '0; v = '0; m.irw = 1; m.pcw = 1; m.srcB = 2'b11; v.irw = 1; v.pcw = 1; v.srcB = 2'b10;
    runInstr(K_LW, opFor(K_LW), 3'b010, 1'b0, -1, -1, 0, m, v);
    m = '0; v = '0; m.regw = 1; m.res = 2'b11; m.imm = 3'b111; v.regw = 1; v.res = 2'b01;
    runInstr(K_LW, opFor(K_LW), 3'b010, 1'b0, -1, -1, 4, m, v);
    m = '0; v = '0; m.memw = 1; m.adr = 1; m.imm = 3'b111; m.regw = 1; v.memw = 1; v.adr = 1; v.imm = 3'b001;
    runInstr(K_SW, opFor(K_SW), 3'b010, 1'b0, -1, -1, 3, m, v);
    m = '0; v = '0; m.pcw = 1; m.alu = 3'b111; m.imm = 3'b111; v.pcw = 1; v.alu = 3'b001; v.imm = 3'b010;
    runInstr(K_BR, opFor(K_BR), 3'b000, 1'b0, 1, -1, 2, m, v);
    m = '0; v = '0; m.pcw = 1;
    runInstr(K_BR, opFor(K_BR), 3'b000, 1'b0, 0, -1, 2, m, v);
    m = '0; v = '0; m.pcw = 1; v.pcw = 1;
    runInstr(K_BR, opFor(K_BR), 3'b001, 1'b0, 0, -1, 2, m, v);
    m = '0; v = '0; m.alu = 3'b111; v.alu = 3'b001;
    runInstr(K_R, opFor(K_R), 3'b000, 1'b1, -1, -1, 2, m, v);
    v.alu = 3'b000;
    runInstr(K_I, opFor(K_I), 3'b000, 1'b1, -1, -1, 2, m, v);
    v.alu = 3'b011;
    runInstr(K_R, opFor(K_R), 3'b110, 1'b0, -1, -1, 2, m, v);
    v.alu = 3'b101;
    runInstr(K_R, opFor(K_R), 3'b010, 1'b0, -1, -1, 2, m, v);
    m = '0; v = '0; m.pcw = 1; m.imm = 3'b111; v.pcw = 1; v.imm = 3'b011;
    runInstr(K_JAL, opFor(K_JAL), 3'b000, 1'b0, -1, -1, 2, m, v);
    m = '0; v = '0; m.res = 2'b11; m.regw = 1; m.imm = 3'b111; v.res = 2'b11; v.regw = 1; v.imm = 3'b100;
    runInstr(K_LUI, opFor(K_LUI), 3'b000, 1'b0, -1, -1, 2, m, v);
    m = '0; v = '0; m.pcw = 1; m.irw = 1; m.regw = 1; m.memw = 1;
    runInstr(K_BAD, 7'b1111111, 3'b000, 1'b0, -1, -1, 1, m, v);

    for (int n = 0; n < 400; n++) begin
      int         kind;
      logic [6:0] o;
      logic [2:0] f3;
      int         abortAt;
      kind = int'($urandom_range(0, 7));
      o    = (kind == K_BAD) ? badOps[$urandom_range(0, 4)] : opFor(kind);
      f3   = (kind == K_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      abortAt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, instrLen(kind) - 1)) : -1;
      runInstr(kind, o, f3, 1'($urandom), -1, abortAt, -1, '0, '0);
    end

    @(posedge clk);
    #1;
    expMode = 0; litActive = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
`default_nettype wire
